data_plane_tx: RTL and testbench

Transmit-side data-plane stage of the communications processor, directly upstream of data_plane_rx across the photonic link. The GPP loads 16-bit payload words into a local TX buffer, then issues a send request with a destination node ID. The block waits for link ownership and serialises a header word plus payload words onto the 32-bit link in the format that data_plane_rx consumes.

---
 rtl/dp_pkg.sv | 29 ++
 rtl/data_plane_tx_if.sv | 31 +++
 rtl/dp_tx_buffer.sv | 51 +++++
 rtl/data_plane_tx.sv | 133 +++++++++++++
 tb/tb_data_plane_tx.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - shared link-word types and FSM states for the data plane
// Purpose : link word layout, idle word, TX state encoding and field widths,
//           shared by data_plane_tx and data_plane_rx.
// Ports   : none (package).
// Config  : TX_CHECKSUM_EN adds the ST_CHECKSUM state.
package dp_pkg;

  localparam int NODE_W = 16;
  localparam int DATA_W = 16;

  typedef struct packed {
    logic [NODE_W-1:0] dest;
    logic [DATA_W-1:0] field;
  } link_word_t;

  localparam logic [NODE_W+DATA_W-1:0] IDLE_WORD = 32'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_GRANT,
    ST_HEADER,
    ST_PAYLOAD,
`ifdef TX_CHECKSUM_EN
    ST_CHECKSUM,
`endif
    ST_DONE
  } tx_state_e;

endpackage

// File: rtl/data_plane_tx_if.sv
// rtl/data_plane_tx_if.sv - GPP and link signal bundle for data_plane_tx
// Purpose : groups the GPP load/start inputs, link grant and link/status outputs.
// Ports   : master drives gpp_wr_en, gpp_wr_data, gpp_dest_id, gpp_tx_start,
//           link_grant; slave (the TX stage) drives data_tx_packet, tx_busy,
//           tx_buf_full, tx_buf_count, data_tx_complete_flag.
interface data_plane_tx_if #(
  parameter int CNT_W = 5
) ();

  logic             gpp_wr_en;
  logic [15:0]      gpp_wr_data;
  logic [15:0]      gpp_dest_id;
  logic             gpp_tx_start;
  logic             link_grant;
  logic [31:0]      data_tx_packet;
  logic             tx_busy;
  logic             tx_buf_full;
  logic [CNT_W-1:0] tx_buf_count;
  logic             data_tx_complete_flag;

  modport master (
    output gpp_wr_en, gpp_wr_data, gpp_dest_id, gpp_tx_start, link_grant,
    input  data_tx_packet, tx_busy, tx_buf_full, tx_buf_count, data_tx_complete_flag
  );

  modport slave (
    input  gpp_wr_en, gpp_wr_data, gpp_dest_id, gpp_tx_start, link_grant,
    output data_tx_packet, tx_busy, tx_buf_full, tx_buf_count, data_tx_complete_flag
  );

endinterface

// File: rtl/dp_tx_buffer.sv
// rtl/dp_tx_buffer.sv - linear-fill TX payload buffer
// Purpose : DEPTH x 16 register array filled from index 0 upward; the count
//           doubles as the write pointer. Read is combinational at rd_idx.
// Ports   : clk, rst (sync, active-high), clr (empty buffer), wr_en/wr_data,
//           rd_idx/rd_data, count, full (count and full are registered).
module dp_tx_buffer
  import dp_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [CNT_W-2:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count,
  output logic              full
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  count_n;
  logic              wr_ok;

  assign wr_ok   = wr_en && !full;
  assign rd_data = mem[rd_idx];

  always_comb begin
    count_n = count;
    if (rst || clr)
      count_n = '0;
    else if (wr_ok)
      count_n = count + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    count <= count_n;
    full  <= (count_n == DEPTH_C);
  end

  // Payload storage needs no reset: only indices below count are ever read.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[count[CNT_W-2:0]] <= wr_data;
  end

endmodule

// File: rtl/data_plane_tx.sv
// rtl/data_plane_tx.sv - transmit-side data-plane stage onto the 32-bit link
// Purpose : buffers GPP payload words, then on start waits for link_grant and
//           sends {dest,len} followed by {dest,data} words, then pulses complete.
// Ports   : clk, rst (sync, active-high), dp (data_plane_tx_if.slave): GPP
//           write/start/dest, link_grant in; data_tx_packet, tx_busy,
//           tx_buf_full, tx_buf_count, data_tx_complete_flag out (all registered).
// Config  : TX_CHECKSUM_EN appends a {dest, XOR of payload} trailer word.
module data_plane_tx
  import dp_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input logic            clk,
  input logic            rst,
  data_plane_tx_if.slave dp
);

  tx_state_e         state, state_n;
  link_word_t        out_q, out_n;
  logic              flag_q, flag_n;
  logic              busy_q;
  logic [CNT_W-1:0]  idx, idx_n;
  logic [CNT_W-1:0]  len_q;
  logic [NODE_W-1:0] dest_q;
  logic              latch, clr;
  logic [DATA_W-1:0] rd_data;
  logic [CNT_W-1:0]  count;
  logic              full;
`ifdef TX_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
`endif

  dp_tx_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .wr_en   (dp.gpp_wr_en && state == ST_IDLE && !dp.gpp_tx_start),
    .wr_data (dp.gpp_wr_data),
    .rd_idx  (idx[CNT_W-2:0]),
    .rd_data (rd_data),
    .count   (count),
    .full    (full)
  );

  // The output word is computed from the current state and registered, so
  // each state's word appears on the link one cycle after that state.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    out_n   = link_word_t'(IDLE_WORD);
    flag_n  = 1'b0;
    latch   = 1'b0;
    clr     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dp.gpp_tx_start && count != '0 && dp.gpp_dest_id != '0) begin
          latch   = 1'b1;
          state_n = ST_WAIT_GRANT;
        end
      end
      ST_WAIT_GRANT: begin
        if (dp.link_grant)
          state_n = ST_HEADER;
      end
      ST_HEADER: begin
        out_n   = '{dest: dest_q, field: {{(DATA_W-CNT_W){1'b0}}, len_q}};
        idx_n   = '0;
        state_n = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        out_n = '{dest: dest_q, field: rd_data};
        idx_n = idx + CNT_W'(1);
        if (idx == len_q - CNT_W'(1))
`ifdef TX_CHECKSUM_EN
          state_n = ST_CHECKSUM;
`else
          state_n = ST_DONE;
`endif
      end
`ifdef TX_CHECKSUM_EN
      ST_CHECKSUM: begin
        out_n   = '{dest: dest_q, field: csum_q};
        state_n = ST_DONE;
      end
`endif
      ST_DONE: begin
        flag_n  = 1'b1;
        clr     = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      out_q  <= link_word_t'(IDLE_WORD);
      flag_q <= 1'b0;
      busy_q <= 1'b0;
      idx    <= '0;
      len_q  <= '0;
      dest_q <= '0;
`ifdef TX_CHECKSUM_EN
      csum_q <= '0;
`endif
    end else begin
      state  <= state_n;
      out_q  <= out_n;
      flag_q <= flag_n;
      busy_q <= (state_n != ST_IDLE);
      idx    <= idx_n;
      if (latch) begin
        len_q  <= count;
        dest_q <= dp.gpp_dest_id;
      end
`ifdef TX_CHECKSUM_EN
      if (latch)
        csum_q <= '0;
      else if (state == ST_PAYLOAD)
        csum_q <= csum_q ^ rd_data;
`endif
    end
  end

  assign dp.data_tx_packet        = out_q;
  assign dp.data_tx_complete_flag = flag_q;
  assign dp.tx_busy               = busy_q;
  assign dp.tx_buf_count          = count;
  assign dp.tx_buf_full           = full;

endmodule

// File: tb/tb_data_plane_tx.sv
// tb/tb_data_plane_tx.sv - directed self-checking bench for data_plane_tx
module tb_data_plane_tx;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  data_plane_tx_if #(.CNT_W(5)) dp_if ();

  data_plane_tx #(.DEPTH(16), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .dp  (dp_if.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic load(input logic [15:0] w);
    dp_if.gpp_wr_en   = 1'b1;
    dp_if.gpp_wr_data = w;
    step();
    dp_if.gpp_wr_en   = 1'b0;
  endtask

  task automatic start(input logic [15:0] d);
    dp_if.gpp_dest_id  = d;
    dp_if.gpp_tx_start = 1'b1;
    step();
    dp_if.gpp_tx_start = 1'b0;
  endtask

  // Called right after start() with link_grant already high; exp_q holds payload.
  task automatic expect_pkt(input logic [15:0] d);
    logic [15:0] cs;
    cs = 16'h0;
    chk("busy_after_start", {31'b0, dp_if.tx_busy}, 32'd1);
    step();
    chk("wait_idle", dp_if.data_tx_packet, 32'h0);
    step();
    chk("header", dp_if.data_tx_packet, {d, 16'(exp_q.size())});
    foreach (exp_q[i]) begin
      step();
      chk("payload", dp_if.data_tx_packet, {d, exp_q[i]});
      cs ^= exp_q[i];
    end
`ifdef TX_CHECKSUM_EN
    step();
    chk("trailer", dp_if.data_tx_packet, {d, cs});
`endif
    step();
    chk("done_idle", dp_if.data_tx_packet, 32'h0);
    chk("done_flag", {31'b0, dp_if.data_tx_complete_flag}, 32'd1);
    chk("done_count", {27'b0, dp_if.tx_buf_count}, 32'd0);
    chk("done_busy", {31'b0, dp_if.tx_busy}, 32'd0);
    step();
    chk("flag_one_cycle", {31'b0, dp_if.data_tx_complete_flag}, 32'd0);
  endtask

  initial begin
    rst                = 1'b1;
    dp_if.gpp_wr_en    = 1'b0;
    dp_if.gpp_wr_data  = 16'h0;
    dp_if.gpp_dest_id  = 16'h0;
    dp_if.gpp_tx_start = 1'b0;
    dp_if.link_grant   = 1'b0;
    step();
    step();
    chk("rst_packet", dp_if.data_tx_packet, 32'h0);
    chk("rst_busy", {31'b0, dp_if.tx_busy}, 32'd0);
    chk("rst_flag", {31'b0, dp_if.data_tx_complete_flag}, 32'd0);
    chk("rst_count", {27'b0, dp_if.tx_buf_count}, 32'd0);
    chk("rst_full", {31'b0, dp_if.tx_buf_full}, 32'd0);
    rst = 1'b0;

    // Basic 3-word packet, grant held high
    dp_if.link_grant = 1'b1;
    load(16'h000A); load(16'h0003); load(16'h0005);
    chk("count3", {27'b0, dp_if.tx_buf_count}, 32'd3);
    exp_q = '{16'h000A, 16'h0003, 16'h0005};
    start(16'h0001);
    expect_pkt(16'h0001);

    // Grant withheld 5 cycles, then dropped mid-payload
    dp_if.link_grant = 1'b0;
    load(16'h1111); load(16'h2222);
    start(16'h0042);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("nogrant_idle", dp_if.data_tx_packet, 32'h0);
      chk("nogrant_busy", {31'b0, dp_if.tx_busy}, 32'd1);
    end
    dp_if.link_grant = 1'b1;
    step();
    chk("grant_seen_idle", dp_if.data_tx_packet, 32'h0);
    step();
    chk("grant_header", dp_if.data_tx_packet, 32'h0042_0002);
    dp_if.link_grant = 1'b0;
    step();
    chk("nostall_p0", dp_if.data_tx_packet, 32'h0042_1111);
    step();
    chk("nostall_p1", dp_if.data_tx_packet, 32'h0042_2222);
`ifdef TX_CHECKSUM_EN
    step();
    chk("nostall_trailer", dp_if.data_tx_packet, 32'h0042_3333);
`endif
    step();
    chk("nostall_flag", {31'b0, dp_if.data_tx_complete_flag}, 32'd1);
    step();

    // Fill past DEPTH; extra words dropped
    dp_if.link_grant = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 18; i++) begin
      load(16'h0100 + 16'(i));
      if (i < 16) exp_q.push_back(16'h0100 + 16'(i));
    end
    chk("full_flag", {31'b0, dp_if.tx_buf_full}, 32'd1);
    chk("full_count", {27'b0, dp_if.tx_buf_count}, 32'd16);
    start(16'h0007);
    expect_pkt(16'h0007);

    // Ignored starts: empty buffer, then dest 0
    start(16'h0005);
    chk("empty_busy", {31'b0, dp_if.tx_busy}, 32'd0);
    step();
    chk("empty_idle", dp_if.data_tx_packet, 32'h0);
    chk("empty_flag", {31'b0, dp_if.data_tx_complete_flag}, 32'd0);
    load(16'h0BBB);
    start(16'h0000);
    chk("dest0_busy", {31'b0, dp_if.tx_busy}, 32'd0);
    step();
    chk("dest0_idle", dp_if.data_tx_packet, 32'h0);
    chk("dest0_count", {27'b0, dp_if.tx_buf_count}, 32'd1);

    // Writes while busy are dropped
    start(16'h0009);
    dp_if.gpp_wr_en   = 1'b1;
    dp_if.gpp_wr_data = 16'hDEAD;
    step();
    step();
    chk("busywr_header", dp_if.data_tx_packet, 32'h0009_0001);
    chk("busywr_count", {27'b0, dp_if.tx_buf_count}, 32'd1);
    dp_if.gpp_wr_en = 1'b0;
    step();
    chk("busywr_payload", dp_if.data_tx_packet, 32'h0009_0BBB);
`ifdef TX_CHECKSUM_EN
    step();
`endif
    step();
    chk("busywr_flag", {31'b0, dp_if.data_tx_complete_flag}, 32'd1);
    load(16'h0CCC);
    exp_q = '{16'h0CCC};
    start(16'h0009);
    expect_pkt(16'h0009);

    // Reset during the 2nd payload word
    load(16'h0001); load(16'h0002); load(16'h0003);
    start(16'h0003);
    step(); step(); step(); step();
    chk("pre_rst_p1", dp_if.data_tx_packet, 32'h0003_0002);
    rst = 1'b1;
    step();
    chk("rst_mid_idle", dp_if.data_tx_packet, 32'h0);
    chk("rst_mid_count", {27'b0, dp_if.tx_buf_count}, 32'd0);
    chk("rst_mid_busy", {31'b0, dp_if.tx_busy}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_idle", dp_if.data_tx_packet, 32'h0);
    load(16'h0777);
    exp_q = '{16'h0777};
    start(16'h0004);
    expect_pkt(16'h0004);

`ifdef TX_CHECKSUM_EN
    load(16'h21FE); load(16'hDEAD);
    start(16'h0001);
    step(); step(); step(); step(); step();
    chk("csum_trailer", dp_if.data_tx_packet, 32'h0001_FF53);
    step();
    chk("csum_flag", {31'b0, dp_if.data_tx_complete_flag}, 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
